ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter that shares the single-port byte RAM between the instruction-fetch (IF) port and the data-memory (DM) load/store port of the softcore CPU. Accepts one request at a time over a req/ready handshake, drives the RAM enable, r/w, address and write-data lines, and returns read data with an rvalid pulse. Sits between the core's fetch/LSU stages and the `ram` instance.

## Interface
Parameters:
- `ADDR_W`, 8, RAM address width (256 words)
- `DATA_W`, 8, RAM word width (byte addressable)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request; held with `if_addr` until `if_ready`
- `if_addr`  in  ADDR_W  fetch address
- `if_ready`  out  1  one-cycle accept pulse to IF
- `if_rvalid`  out  1  one-cycle pulse, `if_rdata` valid
- `if_rdata`  out  DATA_W  fetched byte
- `dm_req`  in  1  data request; held with `dm_we`/`dm_addr`/`dm_wdata` until `dm_ready`
- `dm_we`  in  1  1 = store, 0 = load
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  store data
- `dm_ready`  out  1  one-cycle accept pulse to DM
- `dm_rvalid`  out  1  one-cycle pulse, `dm_rdata` valid (loads only)
- `dm_rdata`  out  DATA_W  loaded byte
- `ram_en`  out  1  RAM enable (drives RAM clock gate)
- `ram_r_w`  out  1  0 = read, 1 = write
- `ram_addr`  out  ADDR_W  RAM address
- `ram_wdata`  out  DATA_W  RAM write data
- `ram_rdata`  in  DATA_W  RAM registered read data

## Operation
- FSM states: IDLE, ACCESS, RESP. All outputs registered.
- IDLE: if any req, pick owner (see arbitration), latch owner, addr, we, wdata; go ACCESS. No req: stay IDLE.
- ACCESS: `ram_en`=1, `ram_r_w`=latched we (always 0 for IF), `ram_addr`/`ram_wdata` = latched values; owner's `*_ready`=1. Write: next IDLE. Read: next RESP.
- RESP: `ram_rdata` captured into owner's `*_rdata`, owner's `*_rvalid`=1; next IDLE.
- `req` inputs ignored in ACCESS and RESP; requester must drop or change req the cycle after ready.
- Arbitration (default): DM has fixed priority over IF when both request in IDLE. IF may starve under continuous DM traffic; accepted.
- `*_rdata` holds last value between rvalid pulses.
- Reset: state IDLE; `ram_en`, `ram_r_w`, `ram_addr`, `ram_wdata`, all ready/rvalid, both rdata = 0; last-grant register = IF.
- Reset mid-operation: access in flight is abandoned; no rvalid issued. A write whose ACCESS cycle coincides with `rst` high still commits to RAM (registered outputs already asserted).

## Timing
- Requests sampled at IDLE edge N; ACCESS in cycle N+1 (ready pulse, RAM enabled); read data valid with rvalid in cycle N+2.
- Read occupancy 3 cycles, write 2 cycles; max throughput one read per 3 cycles.
- `ready` and `rvalid` never asserted to both ports in the same cycle.
- `ram_en` asserted exactly one cycle per accepted request.

## Configuration
- `RAM_ARB_ROUND_ROBIN_EN` defined: contested IDLE grant goes to the port not granted last; last-grant register updates on every grant. Uncontested requests granted immediately.
- Not defined: fixed DM-over-IF priority; last-grant register absent.

## Structure
- Shared package `ram_arb_pkg`: state enum (IDLE/ACCESS/RESP), owner encoding (OWN_IF=0, OWN_DM=1), `ADDR_W`/`DATA_W` defaults.
- Sub-module `ram_arb_pick`: combinational grant selection from `if_req`, `dm_req`, last grant; isolates the macro-dependent policy.

## Test plan
- Reset: assert `rst` 2 cycles -> all outputs 0, state IDLE; release, no req -> `ram_en` stays 0.
- IF read: RAM[0x10]=0xA5, `if_req`, `if_addr`=0x10 at N -> `if_ready` at N+1 with `ram_en`=1, `ram_r_w`=0, `ram_addr`=0x10; `if_rvalid`, `if_rdata`=0xA5 at N+2.
- DM store then load: store 0x3C to 0x80 -> `dm_ready` at N+1, `ram_r_w`=1, `ram_wdata`=0x3C, no rvalid; load 0x80 -> `dm_rdata`=0x3C.
- Contention: both req same cycle (IF 0x01, DM 0x02) -> default: DM granted first, IF next IDLE; with `RAM_ARB_ROUND_ROBIN_EN`, four back-to-back contested rounds alternate DM, IF, DM, IF.
- Reset mid-read: `rst` during ACCESS of read -> no rvalid afterwards, outputs 0, next request served normally.
- Back-to-back: held IF req after ready -> second access starts 1 cycle after RESP; `ram_en` never high two consecutive cycles.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for the IF/DM RAM arbiter: FSM states, owner encoding and
// default RAM geometry.
package ram_arb_pkg;

   localparam int ADDR_W_DEFAULT = 8;
   localparam int DATA_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the fetch/LSU requesters, the arbiter and the byte RAM.
// The slave modport is the arbiter's view; master is the CPU/RAM side.
interface ram_arbiter_if import ram_arb_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT
) ();

   // Handshake: a requester holds req and its request fields stable until it
   // sees a one-cycle ready pulse; a read then returns data with a one-cycle
   // rvalid pulse on the following cycle. req is ignored while a request is
   // being served.
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ready;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_ready;
   logic              dm_rvalid;
   logic [DATA_W-1:0] dm_rdata;

   logic              ram_en;
   logic              ram_r_w;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
      output if_ready, if_rvalid, if_rdata, dm_ready, dm_rvalid, dm_rdata,
      output ram_en, ram_r_w, ram_addr, ram_wdata
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
      input  if_ready, if_rvalid, if_rdata, dm_ready, dm_rvalid, dm_rdata,
      input  ram_en, ram_r_w, ram_addr, ram_wdata
   );

endinterface

// File: rtl/ram_arb_pick.sv
// Grant selection between IF and DM requests. Fixed DM priority by default;
// RAM_ARB_ROUND_ROBIN_EN switches contested grants to alternate via last grant.
module ram_arb_pick import ram_arb_pkg::*; (
   input  logic   if_req,
   input  logic   dm_req,
`ifdef RAM_ARB_ROUND_ROBIN_EN
   input  owner_t last,
`endif
   output logic   grant,
   output owner_t owner
);

   always_comb begin
      grant = if_req | dm_req;
      owner = OWN_IF;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      if (if_req && dm_req) begin
         owner = (last == OWN_DM) ? OWN_IF : OWN_DM;
      end else if (dm_req) begin
         owner = OWN_DM;
      end
`else
      if (dm_req) begin
         owner = OWN_DM;
      end
`endif
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port byte RAM between instruction fetch and data memory.
// Define RAM_ARB_ROUND_ROBIN_EN for alternating grants under contention.
module ram_arbiter import ram_arb_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   ram_arbiter_if.slave bus,
   output state_t       state
);

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   logic              ram_en_q, ram_en_d;
   logic              ram_r_w_q, ram_r_w_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              if_ready_q, if_ready_d;
   logic              dm_ready_q, dm_ready_d;
   logic              if_rvalid_q, if_rvalid_d;
   logic              dm_rvalid_q, dm_rvalid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              gnt;
   owner_t            gnt_owner;

`ifdef RAM_ARB_ROUND_ROBIN_EN
   owner_t            last_q, last_d;
`endif

   ram_arb_pick u_pick (
      .if_req (bus.if_req),
      .dm_req (bus.dm_req),
`ifdef RAM_ARB_ROUND_ROBIN_EN
      .last   (last_q),
`endif
      .grant  (gnt),
      .owner  (gnt_owner)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      ram_en_d    = 1'b0;
      ram_r_w_d   = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      if_ready_d  = 1'b0;
      dm_ready_d  = 1'b0;
      if_rvalid_d = 1'b0;
      dm_rvalid_d = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_d      = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (gnt) begin
               state_d  = ACCESS;
               owner_d  = gnt_owner;
               ram_en_d = 1'b1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
               last_d   = gnt_owner;
`endif
               if (gnt_owner == OWN_DM) begin
                  ram_r_w_d   = bus.dm_we;
                  ram_addr_d  = bus.dm_addr;
                  ram_wdata_d = bus.dm_wdata;
                  dm_ready_d  = 1'b1;
               end else begin
                  ram_addr_d  = bus.if_addr;
                  if_ready_d  = 1'b1;
               end
            end
         end
         ACCESS: begin
            // ram_r_w_q still holds the latched direction of this access.
            if (ram_r_w_q) begin
               state_d = IDLE;
            end else begin
               state_d     = RESP;
               if_rvalid_d = (owner_q == OWN_IF);
               dm_rvalid_d = (owner_q == OWN_DM);
            end
         end
         RESP: begin
            state_d = IDLE;
            if (owner_q == OWN_DM) begin
               dm_rdata_d = bus.ram_rdata;
            end else begin
               if_rdata_d = bus.ram_rdata;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         ram_en_q    <= 1'b0;
         ram_r_w_q   <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         if_ready_q  <= 1'b0;
         dm_ready_q  <= 1'b0;
         if_rvalid_q <= 1'b0;
         dm_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
         last_q      <= OWN_IF;
`endif
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         ram_en_q    <= ram_en_d;
         ram_r_w_q   <= ram_r_w_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         if_ready_q  <= if_ready_d;
         dm_ready_q  <= dm_ready_d;
         if_rvalid_q <= if_rvalid_d;
         dm_rvalid_q <= dm_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
         last_q      <= last_d;
`endif
      end
   end

   // The RAM's registered read data only arrives in the RESP cycle, so during
   // the rvalid pulse it is forwarded; the held copy covers every other cycle.
   assign bus.if_rdata  = if_rvalid_q ? bus.ram_rdata : if_rdata_q;
   assign bus.dm_rdata  = dm_rvalid_q ? bus.ram_rdata : dm_rdata_q;
   assign bus.if_ready  = if_ready_q;
   assign bus.dm_ready  = dm_ready_q;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.dm_rvalid = dm_rvalid_q;
   assign bus.ram_en    = ram_en_q;
   assign bus.ram_r_w   = ram_r_w_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign state         = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: byte RAM model, transaction-level schedule/data model,
// directed cases from the test plan plus randomized single and contested requests.
module tb_ram_arbiter;
   import ram_arb_pkg::*;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   state_t state;

   ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .state (state)
   );

   always #5 clk = ~clk;

   // Byte RAM with registered read, plus a back-door write port for preloading.
   logic [7:0] ram_mem [256];
   logic [7:0] ram_q = 8'h00;
   logic       pre_we = 1'b0;
   logic [7:0] pre_addr = 8'h00;
   logic [7:0] pre_data = 8'h00;

   always @(posedge clk) begin
      if (pre_we) begin
         ram_mem[pre_addr] <= pre_data;
      end else if (bus.ram_en) begin
         if (bus.ram_r_w) ram_mem[bus.ram_addr] <= bus.ram_wdata;
         else             ram_q <= ram_mem[bus.ram_addr];
      end
   end
   assign bus.ram_rdata = ram_q;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] model_mem [256];
   logic [7:0] exp_q [$];
   owner_t     last_gnt = OWN_IF;
   logic [7:0] last_if  = 8'h00;
   logic [7:0] last_dm  = 8'h00;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      tick();
      pre_we = 1'b0;
      model_mem[a] = d;
   endtask

   task automatic model_reset();
      last_gnt = OWN_IF;
      last_if  = 8'h00;
      last_dm  = 8'h00;
      exp_q.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_state"}, state, IDLE);
      check({tag, "_ram_en"}, bus.ram_en, 0);
      check({tag, "_ram_r_w"}, bus.ram_r_w, 0);
      check({tag, "_ram_addr"}, bus.ram_addr, 0);
      check({tag, "_ram_wdata"}, bus.ram_wdata, 0);
      check({tag, "_ready"}, {bus.if_ready, bus.dm_ready}, 0);
      check({tag, "_rvalid"}, {bus.if_rvalid, bus.dm_rvalid}, 0);
      check({tag, "_if_rdata"}, bus.if_rdata, 0);
      check({tag, "_dm_rdata"}, bus.dm_rdata, 0);
   endtask

   // Issue an IF read and/or a DM access in the same cycle. The expected
   // schedule follows the documented timing: the winner is ready one cycle
   // later, a read returns one cycle after ready, a read occupies the RAM for
   // 3 cycles and a write for 2, so the loser is accepted right after that.
   task automatic run_txn(input bit use_if, input bit use_dm, input logic [7:0] ia,
                          input logic dwe, input logic [7:0] da, input logic [7:0] dwd);
      bit         dm_first;
      int         t_ifr, t_dmr, t_ifv, t_dmv, t_end;
      logic [7:0] e;
      if (use_if && use_dm) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
         dm_first = (last_gnt == OWN_IF);
`else
         dm_first = 1'b1;
`endif
      end else begin
         dm_first = use_dm;
      end
      t_ifr = 0; t_dmr = 0; t_ifv = 0; t_dmv = 0;
      if (dm_first) begin
         t_dmr = 1;
         if (dwe) model_mem[da] = dwd;
         else begin exp_q.push_back(model_mem[da]); t_dmv = 2; end
         last_gnt = OWN_DM;
         if (use_if) begin
            t_ifr = dwe ? 3 : 4;
            t_ifv = t_ifr + 1;
            exp_q.push_back(model_mem[ia]);
            last_gnt = OWN_IF;
         end
      end else begin
         t_ifr = 1; t_ifv = 2;
         exp_q.push_back(model_mem[ia]);
         last_gnt = OWN_IF;
         if (use_dm) begin
            t_dmr = 4;
            if (dwe) model_mem[da] = dwd;
            else begin exp_q.push_back(model_mem[da]); t_dmv = 5; end
            last_gnt = OWN_DM;
         end
      end
      t_end = t_ifr;
      if (t_ifv > t_end) t_end = t_ifv;
      if (t_dmr > t_end) t_end = t_dmr;
      if (t_dmv > t_end) t_end = t_dmv;
      t_end = t_end + 1;

      bus.if_req = use_if; bus.if_addr = ia;
      bus.dm_req = use_dm; bus.dm_we = dwe; bus.dm_addr = da; bus.dm_wdata = dwd;
      for (int t = 1; t <= t_end; t++) begin
         tick();
         check("if_ready", bus.if_ready, (t == t_ifr));
         check("dm_ready", bus.dm_ready, (t == t_dmr));
         check("if_rvalid", bus.if_rvalid, (t == t_ifv));
         check("dm_rvalid", bus.dm_rvalid, (t == t_dmv));
         check("ram_en", bus.ram_en, (t == t_ifr) || (t == t_dmr));
         if (t == t_ifr) begin
            check("if_ram_addr", bus.ram_addr, ia);
            check("if_ram_r_w", bus.ram_r_w, 0);
            bus.if_req = 1'b0;
         end
         if (t == t_dmr) begin
            check("dm_ram_addr", bus.ram_addr, da);
            check("dm_ram_r_w", bus.ram_r_w, dwe);
            if (dwe) check("dm_ram_wdata", bus.ram_wdata, dwd);
            bus.dm_req = 1'b0;
         end
         if (t == t_ifv || t == t_dmv) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = 8'h00;
            if (t == t_ifv) begin check("if_rdata", bus.if_rdata, e); last_if = e; end
            else begin check("dm_rdata", bus.dm_rdata, e); last_dm = e; end
         end
      end
      check("end_state", state, IDLE);
      check("if_rdata_hold", bus.if_rdata, last_if);
      check("dm_rdata_hold", bus.dm_rdata, last_dm);
   endtask

   initial begin
      bus.if_req = 1'b0; bus.if_addr = 8'h00;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 8'h00; bus.dm_wdata = 8'h00;

      // Preload RAM and model while reset is held.
      for (int a = 0; a < 256; a++) poke(8'(a), 8'($urandom_range(0, 255)));

      tick();
      tick();
      check_all_zero("reset");
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         tick();
         check("idle_ram_en", bus.ram_en, 0);
         check("idle_state", state, IDLE);
      end

      poke(8'h10, 8'hA5);
      run_txn(1, 0, 8'h10, 0, 8'h00, 8'h00);

      run_txn(0, 1, 8'h00, 1, 8'h80, 8'h3C);
      run_txn(0, 1, 8'h00, 0, 8'h80, 8'h00);

      poke(8'h01, 8'h11);
      poke(8'h02, 8'h22);
      run_txn(1, 1, 8'h01, 0, 8'h02, 8'h00);
      run_txn(1, 1, 8'h01, 0, 8'h02, 8'h00);

      // Reset while a read is in its ACCESS cycle.
      poke(8'h20, 8'h5A);
      bus.if_req = 1'b1; bus.if_addr = 8'h20;
      tick();
      check("rst_mid_if_ready", bus.if_ready, 1);
      bus.if_req = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_all_zero("rst_mid");
      model_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_mid_no_rvalid", bus.if_rvalid, 0);
      end
      run_txn(1, 0, 8'h20, 0, 8'h00, 8'h00);

      // IF request held across its own ready: re-accepted one cycle after RESP.
      poke(8'h30, 8'h77);
      bus.if_req = 1'b1; bus.if_addr = 8'h30;
      for (int t = 1; t <= 6; t++) begin
         tick();
         check("b2b_if_ready", bus.if_ready, (t == 1) || (t == 4));
         check("b2b_ram_en", bus.ram_en, (t == 1) || (t == 4));
         check("b2b_if_rvalid", bus.if_rvalid, (t == 2) || (t == 5));
         if (t == 2 || t == 5) check("b2b_if_rdata", bus.if_rdata, 8'h77);
         if (t == 4) bus.if_req = 1'b0;
      end
      check("b2b_state", state, IDLE);
      last_if  = 8'h77;
      last_gnt = OWN_IF;

      // Randomized single and contested requests over a small address window.
      for (int i = 0; i < 80; i++) begin
         int k;
         k = $urandom_range(0, 2);
         run_txn(k != 1, k != 0, 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
         if ($urandom_range(0, 3) == 0) tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
